// File: rtl/imem_b_arbiter.sv
// Two-requester arbiter for i_mem port B: round-robin with a requester-0 lock,
// registered port drive and a two-stage read-response tag pipeline.
module imem_b_arbiter #(
    parameter int unsigned WADR_W = 14
) (
    input  logic              Clock,
    input  logic              Rst,

    input  logic              r0_valid,
    input  logic              r0_wr,
    input  logic [WADR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_byteen,
    input  logic              r0_lock,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    output logic [31:0]       r0_rsp_data,

    input  logic              r1_valid,
    input  logic              r1_wr,
    input  logic [WADR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_byteen,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [31:0]       r1_rsp_data,

    output logic [WADR_W-1:0] address_b,
    output logic [31:0]       data_b,
    output logic              wren_b,
    output logic [3:0]        byteena_b,
    input  logic [31:0]       q_b
);

    typedef enum logic {
        ARB   = 1'b0,
        LOCK0 = 1'b1
    } state_t;

    state_t            state;
    logic              last_grant;   // 1: requester 1 was granted last
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel_wr;
    logic [WADR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_byteen;
    logic              rd_v1;
    logic              rd_id1;
    logic              rd_v2;
    logic              rd_id2;

    // Same-cycle grant decision; nothing is granted while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Rst) begin
            if (state == LOCK0) begin
                grant0 = r0_valid;
            end else if (r0_valid && r1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = r0_valid;
                grant1 = r1_valid;
            end
        end
    end

    always_comb begin
        accept     = grant0 | grant1;
        sel_wr     = grant1 ? r1_wr     : r0_wr;
        sel_addr   = grant1 ? r1_addr   : r0_addr;
        sel_wdata  = grant1 ? r1_wdata  : r0_wdata;
        sel_byteen = grant1 ? r1_byteen : r0_byteen;
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state      <= ARB;
            last_grant <= 1'b1;
            address_b  <= '0;
            data_b     <= '0;
            wren_b     <= 1'b0;
            byteena_b  <= '0;
            rd_v1      <= 1'b0;
            rd_id1     <= 1'b0;
            rd_v2      <= 1'b0;
            rd_id2     <= 1'b0;
        end else begin
            if (state == ARB) begin
                if (grant0 && r0_lock) begin
                    state <= LOCK0;
                end
            end else if (!r0_lock) begin
                state <= ARB;
            end

            // Port outputs hold their last request; only the write strobe drops.
            if (accept) begin
                last_grant <= grant1;
                address_b  <= sel_addr;
                data_b     <= sel_wdata;
                byteena_b  <= sel_byteen;
            end
            wren_b <= accept & sel_wr;

            rd_v1  <= accept & !sel_wr;
            rd_id1 <= grant1;
            rd_v2  <= rd_v1;
            rd_id2 <= rd_id1;
        end
    end

    // q_b is valid in the cycle the second pipeline stage is occupied.
    assign r0_rsp_valid = rd_v2 && !rd_id2;
    assign r1_rsp_valid = rd_v2 &&  rd_id2;
    assign r0_rsp_data  = r0_rsp_valid ? q_b : 32'h0;
    assign r1_rsp_data  = r1_rsp_valid ? q_b : 32'h0;

endmodule

// File: doc/imem_b_arbiter.md
IMEM_B_ARBITER -- requirements
Module: imem_b_arbiter

Interface
REQ-001 Parameter WADR_W, default 14, word-address width of i_mem port B.
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  synchronous, active-high reset.
REQ-004 r0_valid  in  1  requester 0 (fabric loader) request.
REQ-005 r0_wr  in  1  requester 0 write (1) / read (0).
REQ-006 r0_addr  in  WADR_W  requester 0 word address.
REQ-007 r0_wdata  in  32  requester 0 write data.
REQ-008 r0_byteen  in  4  requester 0 byte enables.
REQ-009 r0_lock  in  1  requester 0 holds ownership of port B.
REQ-010 r0_ready  out  1  requester 0 request accepted this cycle.
REQ-011 r0_rsp_valid  out  1  requester 0 read data valid.
REQ-012 r0_rsp_data  out  32  requester 0 read data.
REQ-013 r1_valid, r1_wr, r1_addr, r1_wdata, r1_byteen, r1_ready, r1_rsp_valid, r1_rsp_data: same directions, widths and meanings for requester 1 (debug); no lock input.
REQ-014 address_b  out  WADR_W  i_mem port B word address.
REQ-015 data_b  out  32  i_mem port B write data.
REQ-016 wren_b  out  1  i_mem port B write enable.
REQ-017 byteena_b  out  4  i_mem port B byte enables.
REQ-018 q_b  in  32  i_mem port B read data, valid one cycle after address_b is presented.

Function
REQ-019 At most one request accepted per cycle; rX_ready SHALL be high only when rX_valid is high and requester X wins arbitration (combinational, same cycle).
REQ-020 Arbitration: round-robin; last_grant register; when both valid and unlocked, the requester not granted last wins; single valid requester wins unconditionally.
REQ-021 FSM states ARB and LOCK0; ARB -> LOCK0 when r0 accepted with r0_lock=1; LOCK0 -> ARB on first cycle r0_lock=0.
REQ-022 In LOCK0 r1_ready SHALL be 0; r0 accepted whenever r0_valid=1; last_grant held at r0.
REQ-023 Accepted request (cycle N) SHALL be registered onto address_b/data_b/byteena_b/wren_b in cycle N+1 only; wren_b=1 only for accepted writes; with no acceptance in N, wren_b=0 in N+1 and other port outputs hold last values.
REQ-024 Accepted read (cycle N): rX_rsp_valid=1 in cycle N+2 for the issuing requester only, rX_rsp_data=q_b in that cycle; rX_rsp_data=0 whenever rX_rsp_valid=0.
REQ-025 Writes produce no response.
REQ-026 Back-to-back accepts SHALL be supported with full throughput; responses returned in issue order, tagged by a 2-stage requester-id pipeline.
REQ-027 Read after write to same address accepted in consecutive cycles SHALL return the newly written data (write reaches memory before the read address).
REQ-028 r0_lock asserted with r0_valid=0 SHALL NOT enter LOCK0.

Reset
REQ-029 On Rst: state=ARB, last_grant=r1 (r0 wins first tie), wren_b=0, address_b=0, data_b=0, byteena_b=0, r0/r1_rsp_valid=0, response pipeline cleared.
REQ-030 Rst mid-operation SHALL drop all in-flight reads (no response in the following cycles) and release LOCK0.
REQ-031 During Rst, r0_ready and r1_ready SHALL be 0.

Verification
REQ-032 After reset, both valid reads (r0 addr 0x10, r1 addr 0x20) held: r0 accepted cycle 0, r1 cycle 1, alternating thereafter; r0_rsp_valid cycle 2, r1_rsp_valid cycle 3 with mem[0x10], mem[0x20].
REQ-033 r0 writes 0xDEADBEEF byteen 4'hF addr 0x5 then r0 reads 0x5 next cycle -> wren_b=1 with address_b=0x5 one cycle after accept; read response 0xDEADBEEF two cycles after read accept.
REQ-034 r0 accepted with r0_lock=1 for 8 cycles while r1_valid=1 -> r1_ready=0 throughout; r1 accepted first cycle after r0_lock drops.
REQ-035 Byte write r1 byteen 4'b0010 data 0x0000AB00 onto word 0x11223344 -> subsequent read returns 0x1122AB44.
REQ-036 Rst asserted one cycle after a read accept -> no rsp_valid for that read; wren_b=0 and state ARB on release.
